// File: rtl/ex_div_pkg.sv
// ex_div_pkg: constants shared by the EX-stage divider.
//   - opcode / funct7 / funct3 values of the RV32M DIV, DIVU, REM, REMU instructions
//   - FSM state encoding for ex_div
//   - ZERO_WORD and WRITE_DISABLE constants used for idle outputs
package ex_div_pkg;

    localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0]  FUNCT3_DIV    = 3'b100;
    localparam logic [2:0]  FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0]  FUNCT3_REM    = 3'b110;
    localparam logic [2:0]  FUNCT3_REMU   = 3'b111;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude for the restoring datapath.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        magnitude = (is_signed && value[31]) ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// div_core: unsigned restoring divider datapath, one quotient bit per cycle.
//   clk, rst_n   : core clock, asynchronous active-low reset
//   load         : capture dividend/divisor, clear remainder and counter
//   step         : perform one shift / trial-subtract / quotient-bit iteration
//   dividend     : unsigned dividend (magnitude)
//   divisor      : unsigned divisor (magnitude, nonzero when stepping)
//   quot, rem    : quotient and partial remainder registers
//   count        : number of iterations completed (wraps after 32)
module div_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic [4:0]  count
);

    logic [31:0] dvsr;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quot_next;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the remainder while the new quotient bit enters at the LSB.
    always_comb begin
        shifted = {rem, quot[31]};
        trial   = {1'b0, shifted} - {2'b00, dvsr};
        if (!trial[33]) begin
            rem_next  = trial[31:0];
            quot_next = {quot[30:0], 1'b1};
        end else begin
            rem_next  = shifted[31:0];
            quot_next = {quot[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr  <= 32'd0;
            rem   <= 32'd0;
            quot  <= 32'd0;
            count <= 5'd0;
        end else if (load) begin
            dvsr  <= divisor;
            rem   <= 32'd0;
            quot  <= dividend;
            count <= 5'd0;
        end else if (step) begin
            rem   <= rem_next;
            quot  <= quot_next;
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/ex_div.sv
// ex_div: EX-stage iterative divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst_n   : core clock, asynchronous active-low reset
//   inst_i       : instruction from ID/EX (all-zero for a bubble)
//   op1_i, op2_i : dividend (rs1) and divisor (rs2)
//   reg_waddr_i  : destination register
//   flush_i      : jump/flush request, aborts a divide in progress
//   div_hold_o   : stall request to ctrl while the divide is busy
//   div_we_o     : one-cycle write enable for the result
//   div_waddr_o  : result destination register
//   div_wdata_o  : quotient or remainder
// Normal divides write 33 cycles after issue; divide-by-zero and signed
// overflow are resolved at issue and write one cycle later.
import ex_div_pkg::*;

module ex_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    output logic        div_hold_o,
    output logic        div_we_o,
    output logic [4:0]  div_waddr_o,
    output logic [31:0] div_wdata_o
);

    div_state_t  state, state_next;

    logic [2:0]  funct3;
    logic        is_div_inst;
    logic        start;
    logic        signed_op;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_word;

    logic [4:0]  waddr;
    logic        is_rem;
    logic        quot_neg;
    logic        rem_neg;
    logic        special_hit;
    logic [31:0] special_result;

    logic [31:0] quot;
    logic [31:0] rem;
    logic [4:0]  count;
    logic [31:0] result;

    // rs1/rs2 fields are not needed: operands arrive already read.
    logic        unused_fields;
    assign unused_fields = ^inst_i[24:15];

    assign funct3      = inst_i[14:12];
    assign is_div_inst = (inst_i[6:0] == OPCODE_OP) && (inst_i[31:25] == FUNCT7_MULDIV) && funct3[2];
    assign start       = is_div_inst && (state == IDLE) && !flush_i;

    assign signed_op   = !funct3[0];
    assign div_zero    = (op2_i == 32'd0);
    assign overflow    = signed_op && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
    assign special     = div_zero || overflow;

    always_comb begin
        special_word = 32'd0;
        if (div_zero) special_word = funct3[1] ? op1_i : 32'hFFFF_FFFF;
        else          special_word = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Operands are captured at issue because ID/EX zeroes its outputs while
    // the pipeline is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr          <= 5'd0;
            is_rem         <= 1'b0;
            quot_neg       <= 1'b0;
            rem_neg        <= 1'b0;
            special_hit    <= 1'b0;
            special_result <= 32'd0;
        end else if (start) begin
            waddr          <= reg_waddr_i;
            is_rem         <= funct3[1];
            quot_neg       <= signed_op && (op1_i[31] ^ op2_i[31]);
            rem_neg        <= signed_op && op1_i[31];
            special_hit    <= special;
            special_result <= special_word;
        end
    end

    div_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start && !special),
        .step     (state == BUSY),
        .dividend (magnitude(op1_i, signed_op)),
        .divisor  (magnitude(op2_i, signed_op)),
        .quot     (quot),
        .rem      (rem),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = special ? DONE : BUSY;
            BUSY: begin
                if (flush_i)             state_next = IDLE;
                else if (count == 5'd31) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quotient is negated on differing signs; remainder follows the dividend.
    always_comb begin
        result = ZERO_WORD;
        if (special_hit)  result = special_result;
        else if (is_rem)  result = rem_neg  ? (32'd0 - rem)  : rem;
        else              result = quot_neg ? (32'd0 - quot) : quot;
    end

    always_comb begin
        div_we_o    = WRITE_DISABLE;
        div_waddr_o = 5'd0;
        div_wdata_o = ZERO_WORD;
        if (state == DONE) begin
            div_waddr_o = waddr;
            div_wdata_o = result;
            if (!flush_i && (waddr != 5'd0)) div_we_o = WRITE_ENABLE;
        end
    end

    // Gated by rst_n so the stall request drops the instant reset asserts.
    assign div_hold_o = rst_n && (start || (state == BUSY));

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        div_hold_o;
    logic        div_we_o;
    logic [4:0]  div_waddr_o;
    logic [31:0] div_wdata_o;

    ex_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_i      (inst_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .div_hold_o  (div_hold_o),
        .div_we_o    (div_we_o),
        .div_waddr_o (div_waddr_o),
        .div_wdata_o (div_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] mkinst(input logic [2:0] f3, input logic [4:0] rd);
        mkinst = {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic clear_inputs();
        inst_i = 32'd0; op1_i = 32'd0; op2_i = 32'd0; reg_waddr_i = 5'd0;
    endtask

    // Compare a write against the scoreboard head.
    task automatic take_write(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected_we"}, {31'd0, div_we_o}, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_waddr"}, {27'd0, div_waddr_o}, {27'd0, e.waddr});
            check({name, "_wdata"}, div_wdata_o, e.wdata);
        end
    endtask

    // Issue one instruction and follow it for up to 40 cycles.
    task automatic run_div(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input int lat);
        bit seen = 0;
        exp_t e;
        @(negedge clk);
        inst_i = mkinst(f3, rd); op1_i = a; op2_i = b; reg_waddr_i = rd;
        #1;
        check({name, "_hold_T"}, {31'd0, div_hold_o}, 32'd1);
        if (rd != 5'd0) begin
            e.waddr = rd; e.wdata = exp;
            sb.push_back(e);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            #1;
            check($sformatf("%s_hold_k%0d", name, k), {31'd0, div_hold_o}, {31'd0, k < lat});
            if (div_we_o) begin
                check({name, "_latency"}, k, lat);
                take_write(name);
                seen = 1;
            end
        end
        if (rd != 5'd0) check({name, "_write_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Watch for stray writes over n cycles.
    task automatic no_write(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            if (div_we_o) check({name, "_stray_we"}, 32'd1, 32'd0);
        end
        check({name, "_we_idle"}, {31'd0, div_we_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0;
        clear_inputs();

        vecs[0]  = '{3'b100, 32'd20,         32'd3,          5'd5,  32'd6,          33};
        vecs[1]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  33};
        vecs[2]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  33};
        vecs[3]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'd1,          33};
        vecs[4]  = '{3'b101, 32'd100,        32'd0,          5'd9,  32'hFFFF_FFFF,  1};
        vecs[5]  = '{3'b111, 32'd100,        32'd0,          5'd10, 32'd100,        1};
        vecs[6]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1};
        vecs[7]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1};
        vecs[8]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd13, 32'hFFFF_FFFF,  33};
        vecs[9]  = '{3'b110, 32'd7,          32'hFFFF_FFFD,  5'd14, 32'd1,          33};
        vecs[10] = '{3'b100, 32'd7,          32'hFFFF_FFFD,  5'd15, 32'hFFFF_FFFE,  33};
        vecs[11] = '{3'b100, 32'd5,          32'd0,          5'd16, 32'hFFFF_FFFF,  1};
        vecs[12] = '{3'b110, 32'hFFFF_FFFB,  32'd0,          5'd17, 32'hFFFF_FFFB,  1};
        vecs[13] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          33};
        vecs[14] = '{3'b100, 32'd20,         32'd3,          5'd0,  32'd6,          33};

        // Reset state, with a divide sitting on the inputs.
        inst_i = mkinst(3'b100, 5'd3); op1_i = 32'd9; op2_i = 32'd3; reg_waddr_i = 5'd3;
        repeat (2) @(negedge clk);
        #1;
        check("rst_we",    {31'd0, div_we_o},   32'd0);
        check("rst_hold",  {31'd0, div_hold_o}, 32'd0);
        check("rst_waddr", {27'd0, div_waddr_o}, 32'd0);
        check("rst_wdata", div_wdata_o,         32'd0);
        clear_inputs();
        @(negedge clk); rst_n = 1'b1;

        // Non-divide instructions: ADD and MUL stay idle.
        @(negedge clk);
        inst_i = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011}; op1_i = 32'd5; op2_i = 32'd7; reg_waddr_i = 5'd4;
        #1; check("add_hold", {31'd0, div_hold_o}, 32'd0);
        @(negedge clk);
        inst_i = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011};
        #1; check("mul_hold", {31'd0, div_hold_o}, 32'd0);
        @(negedge clk); clear_inputs();
        no_write("nondiv", 4);

        for (int i = 0; i < 15; i++)
            run_div($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                    vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // Flush in BUSY at T+10.
        @(negedge clk);
        inst_i = mkinst(3'b100, 5'd20); op1_i = 32'd20; op2_i = 32'd3; reg_waddr_i = 5'd20;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            flush_i = (k == 10);
        end
        #1; check("flush_hold_low", {31'd0, div_hold_o}, 32'd0);
        no_write("flush", 40);
        run_div("after_flush", 3'b100, 32'd9, 32'd3, 5'd21, 32'd3, 33);

        // Flush landing in DONE suppresses the write in that same cycle.
        @(negedge clk);
        inst_i = mkinst(3'b100, 5'd22); op1_i = 32'd20; op2_i = 32'd3; reg_waddr_i = 5'd22;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
        end
        flush_i = 1'b1;
        #1; check("flush_done_we", {31'd0, div_we_o}, 32'd0);
        @(negedge clk); flush_i = 1'b0;
        no_write("flush_done", 40);

        // Reset asserted at T+15 mid-divide.
        @(negedge clk);
        inst_i = mkinst(3'b100, 5'd23); op1_i = 32'd20; op2_i = 32'd3; reg_waddr_i = 5'd23;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_hold",  {31'd0, div_hold_o}, 32'd0);
        check("midrst_we",    {31'd0, div_we_o},   32'd0);
        check("midrst_wdata", div_wdata_o,         32'd0);
        @(negedge clk); rst_n = 1'b1;
        no_write("after_rst", 40);
        run_div("post_rst", 3'b100, 32'd8, 32'd2, 5'd24, 32'd4, 33);

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
